// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern generator: count up/down, bouncing scanner and PWM breathing,
// stepped by the carry of a SPEED-driven accumulator.
module led_pattern_gen #(
   parameter int N_LED   = 8,
   parameter int CNT_W   = 26,
   parameter int SPEED_W = 4,
   parameter int PWM_W   = 8
) (
   input  logic               FPGA_CLK1_50,
   input  logic               RESET_N,
   input  logic [SPEED_W-1:0] SPEED,
   input  logic [1:0]         MODE,
   input  logic               HOLD,
   output logic [N_LED-1:0]   LED,
   output logic               STEP
);

   typedef enum logic [1:0] {
      M_COUNT_UP   = 2'd0,
      M_COUNT_DOWN = 2'd1,
      M_SCAN       = 2'd2,
      M_BREATHE    = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [N_LED-1:0] P_ONE     = N_LED'(1);
   localparam logic [PWM_W-1:0] LEVEL_ONE = PWM_W'(1);
   localparam logic [PWM_W-1:0] LEVEL_MAX = {PWM_W{1'b1}};

   logic [CNT_W-1:0] acc, acc_n;
   logic [CNT_W:0]   sum;
   logic [N_LED-1:0] p, p_n, led_n;
   logic [PWM_W-1:0] level, level_n, pwm_cnt;
   dir_t             dir, dir_n;
   mode_t            mode_q, mode_in;
   logic             step_n;

   assign mode_in = mode_t'(MODE);
   assign sum     = {1'b0, acc} + {{(CNT_W + 1 - SPEED_W){1'b0}}, SPEED};

   always_comb begin
      acc_n   = acc;
      p_n     = p;
      level_n = level;
      dir_n   = dir;
      step_n  = 1'b0;
      // A mode change re-initialises the new mode and swallows any carry on that edge.
      if (mode_in != mode_q) begin
         acc_n = '0;
         unique case (mode_in)
            M_SCAN: begin
               p_n   = P_ONE;
               dir_n = DIR_UP;
            end
            M_BREATHE: begin
               level_n = '0;
               dir_n   = DIR_UP;
            end
            default: p_n = '0;
         endcase
      end else if (!HOLD) begin
         acc_n  = sum[CNT_W-1:0];
         step_n = sum[CNT_W];
         if (sum[CNT_W]) begin
            unique case (mode_in)
               M_COUNT_UP:   p_n = p + P_ONE;
               M_COUNT_DOWN: p_n = p - P_ONE;
               M_SCAN: begin
                  if (N_LED == 1 || !$onehot(p)) begin
                     p_n = P_ONE;
                  end else if (dir == DIR_UP) begin
                     p_n = p << 1;
                     if (p_n[N_LED-1]) dir_n = DIR_DOWN;
                  end else begin
                     p_n = p >> 1;
                     if (p_n[0]) dir_n = DIR_UP;
                  end
               end
               M_BREATHE: begin
                  if (dir == DIR_UP) begin
                     level_n = level + LEVEL_ONE;
                     if (level_n == LEVEL_MAX) dir_n = DIR_DOWN;
                  end else begin
                     level_n = level - LEVEL_ONE;
                     if (level_n == '0) dir_n = DIR_UP;
                  end
               end
            endcase
         end
      end
      led_n = (mode_in == M_BREATHE) ? {N_LED{pwm_cnt < level_n}} : p_n;
   end

   always_ff @(posedge FPGA_CLK1_50) begin
      if (!RESET_N) begin
         acc     <= '0;
         p       <= '0;
         level   <= '0;
         dir     <= DIR_UP;
         pwm_cnt <= '0;
         mode_q  <= M_COUNT_UP;
         LED     <= '0;
         STEP    <= 1'b0;
      end else begin
         acc     <= acc_n;
         p       <= p_n;
         level   <= level_n;
         dir     <= dir_n;
         pwm_cnt <= pwm_cnt + LEVEL_ONE;
         mode_q  <= mode_in;
         LED     <= led_n;
         STEP    <= step_n;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed phases plus random traffic against an integer reference model.
module tb_led_pattern_gen;
   localparam int N_LED = 4, CNT_W = 4, SPEED_W = 4, PWM_W = 3;

   // clock / reset
   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic               rst_n, hold, step;
   logic [1:0]         mode;
   logic [SPEED_W-1:0] speed;
   logic [N_LED-1:0]   led;

   led_pattern_gen #(.N_LED(N_LED), .CNT_W(CNT_W), .SPEED_W(SPEED_W), .PWM_W(PWM_W)) dut (
      .FPGA_CLK1_50 (clk),
      .RESET_N      (rst_n),
      .SPEED        (speed),
      .MODE         (mode),
      .HOLD         (hold),
      .LED          (led),
      .STEP         (step)
   );

   int checks = 0, failures = 0;
   logic [N_LED:0] exp_q[$];

   // reference model: counter value, scan position index, triangle level
   int m_acc, m_cnt, m_pos, m_level, m_pwm, m_mode_q;
   bit m_scan_up, m_br_up;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int total, pwm_before;
      bit st;
      logic [N_LED-1:0] e_led;
      st = 1'b0;
      if (!rst_n) begin
         m_acc = 0; m_cnt = 0; m_pos = 0; m_level = 0; m_pwm = 0; m_mode_q = 0;
         m_scan_up = 1; m_br_up = 1;
         exp_q.push_back('0);
         return;
      end
      pwm_before = m_pwm;
      m_pwm = (m_pwm + 1) % (1 << PWM_W);
      if (int'(mode) != m_mode_q) begin
         m_acc = 0; m_cnt = 0; m_pos = 0; m_level = 0; m_scan_up = 1; m_br_up = 1;
      end else if (!hold) begin
         total = m_acc + int'(speed);
         st = (total >= (1 << CNT_W));
         m_acc = total % (1 << CNT_W);
         if (st) begin
            case (mode)
               2'd0: m_cnt = (m_cnt + 1) % (1 << N_LED);
               2'd1: m_cnt = (m_cnt + (1 << N_LED) - 1) % (1 << N_LED);
               2'd2: begin
                  m_pos = m_scan_up ? m_pos + 1 : m_pos - 1;
                  if (m_pos == N_LED - 1) m_scan_up = 0;
                  if (m_pos == 0) m_scan_up = 1;
               end
               default: begin
                  m_level = m_br_up ? m_level + 1 : m_level - 1;
                  if (m_level == (1 << PWM_W) - 1) m_br_up = 0;
                  if (m_level == 0) m_br_up = 1;
               end
            endcase
         end
      end
      m_mode_q = int'(mode);
      if (mode == 2'd3) e_led = (pwm_before < m_level) ? '1 : '0;
      else if (mode == 2'd2) e_led = N_LED'(1 << m_pos);
      else e_led = N_LED'(m_cnt);
      exp_q.push_back({st, e_led});
   endtask

   // driver: one clock edge, model update, sample #1 later, scoreboard compare
   task automatic tick(input string tag);
      logic [N_LED:0] e;
      @(posedge clk);
      model_edge();
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_led"}, 32'(led), 32'(e[N_LED-1:0]));
         check({tag, "_step"}, 32'(step), 32'(e[N_LED]));
      end
   endtask

   initial begin
      int n, lit, waited;
      bit found;
      logic [N_LED-1:0] scan_tbl[7];
      scan_tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

      rst_n = 1'b0; hold = 1'b0; mode = 2'd0; speed = 4'd1;
      for (int i = 0; i < 3; i++) tick("reset");
      check("reset_led", 32'(led), 32'd0);
      check("reset_step", 32'(step), 32'd0);

      // count up, SPEED=1: one step per 16 clocks, wrap after 16 steps
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 256; i++) begin
         tick("up");
         if (step) n++;
      end
      check("up_steps", 32'(n), 32'd16);
      check("up_wrap", 32'(led), 32'd0);

      // count down, SPEED=4, then SPEED=0 freezes
      mode = 2'd1; speed = 4'd4;
      tick("down_init");
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick("down");
         if (step) n++;
      end
      check("down_steps", 32'(n), 32'd10);
      speed = 4'd0; n = 0;
      for (int i = 0; i < 40; i++) begin
         tick("speed0");
         if (step) n++;
      end
      check("speed0_steps", 32'(n), 32'd0);

      // HOLD in count up
      mode = 2'd0; speed = 4'd3;
      for (int i = 0; i < 10; i++) tick("pre_hold");
      hold = 1'b1; n = 0;
      for (int i = 0; i < 50; i++) begin
         tick("hold");
         if (step) n++;
      end
      check("hold_steps", 32'(n), 32'd0);
      hold = 1'b0;
      for (int i = 0; i < 20; i++) tick("post_hold");

      // mode change on the carry edge
      speed = 4'd5; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_acc + 5 >= 16) found = 1;
         else tick("seek_carry");
      end
      check("carry_found", 32'(found), 32'd1);
      mode = 2'd1;
      tick("chg_on_carry");
      check("chg_step", 32'(step), 32'd0);
      check("chg_led", 32'(led), 32'd0);

      // scan bounce
      mode = 2'd2; speed = 4'd8;
      tick("scan_init");
      check("scan_init_val", 32'(led), 32'd1);
      for (int k = 0; k < 7; k++) begin
         waited = 0;
         do begin
            tick("scan");
            waited++;
         end while (!step && waited < 4);
         check($sformatf("scan_seq%0d", k), 32'(led), 32'(scan_tbl[k]));
      end

      // reset while showing 0100
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick("seek_0100");
         if (m_pos == 2) found = 1;
      end
      check("found_0100", 32'(found), 32'd1);
      rst_n = 1'b0;
      tick("mid_reset");
      check("mid_reset_led", 32'(led), 32'd0);
      rst_n = 1'b1;
      tick("reset_to_scan");
      check("reset_to_scan_led", 32'(led), 32'd1);

      // breathe: level 0 dark, level 3 lit 3 of 8 clocks
      mode = 2'd3; speed = 4'd15;
      tick("br_init");
      hold = 1'b1; lit = 0;
      for (int i = 0; i < 8; i++) begin
         tick("br_lvl0");
         if (led == 4'hF) lit++;
      end
      check("br_lvl0_lit", 32'(lit), 32'd0);
      hold = 1'b0; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick("br_seek3");
         if (m_level == 3) found = 1;
      end
      check("br_found3", 32'(found), 32'd1);
      hold = 1'b1; lit = 0;
      for (int i = 0; i < 8; i++) begin
         tick("br_lvl3");
         if (led == 4'hF) lit++;
      end
      check("br_lvl3_lit", 32'(lit), 32'd3);
      hold = 1'b0;
      for (int i = 0; i < 60; i++) tick("br_ramp");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         speed = 4'($urandom_range(0, 15));
         hold  = ($urandom_range(0, 9) == 0);
         rst_n = ($urandom_range(0, 49) != 0);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the board's free-running LED counter.
- Drives N_LED LEDs from a prescaled step tick in one of four display modes: count up, count down, bouncing scanner, and PWM "breathing".
- The step rate is set by a SPEED input that accumulates into the prescaler.
- Sits directly between the board switches/keys and the LED pins; top level maps KEY/SW onto RESET_N, HOLD, MODE and SPEED.

Parameters:
- N_LED, 8, number of LED outputs (>=1).
- CNT_W, 26, prescaler accumulator width; step period = 2^CNT_W / SPEED clocks.
- SPEED_W, 4, width of SPEED input (SPEED_W <= CNT_W).
- PWM_W, 8, breathing brightness resolution; PWM period = 2^PWM_W clocks.

Ports:
- FPGA_CLK1_50  in  1  single system clock, all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- SPEED  in  SPEED_W  prescaler increment per clock; 0 = no steps.
- MODE  in  2  0 COUNT_UP, 1 COUNT_DOWN, 2 SCAN, 3 BREATHE.
- HOLD  in  1  1 = freeze prescaler and pattern state.
- LED  out  N_LED  LED drive, registered.
- STEP  out  1  one-cycle pulse, coincident with each pattern advance.

Behaviour:
- Reset (RESET_N=0 at clock edge) has priority over everything. It clears:
  - acc = 0, P = 0, level = 0, dir = up, pwm_cnt = 0, mode_q = 0;
  - LED = 0, STEP = 0.
- Prescaler, when HOLD=0: {carry, acc} <= acc + SPEED, computed CNT_W+1 bits wide.
  - STEP <= carry; the pattern advances on the same edge.
  - New LED value and STEP=1 become visible in the same cycle.
  - When HOLD=1: acc, P, level and dir hold; STEP <= 0.
- Mode change: mode_q <= MODE every cycle. If MODE != mode_q at an edge, that edge re-initialises:
  - acc <= 0, STEP <= 0, no advance;
  - P <= 0 for modes 0/1, P <= 1 (bit0) with dir=up for mode 2, level <= 0 with dir=up for mode 3.
  - Re-init happens even when HOLD=1, and wins over a simultaneous carry.
- COUNT_UP advance: P <= P + 1, wraps at 2^N_LED-1 to 0. LED = P.
- COUNT_DOWN advance: P <= P - 1, wraps at 0 to 2^N_LED-1. LED = P.
- SCAN: P is one-hot.
  - dir=up: shift left.
  - When the advance lands on bit N_LED-1, set dir=down; when it lands on bit 0, set dir=up. End bits are therefore shown for one step only.
  - N_LED=1: P stays 1.
  - If P is found not one-hot (e.g. mode 2 entered straight out of reset before re-init), the next advance loads 1.
  - LED = P.
- BREATHE:
  - pwm_cnt (PWM_W bits) increments every clock regardless of HOLD and wraps.
  - Each advance steps level (PWM_W bits) by ±1. At level = 2^PWM_W-1 set dir=down; at level 0 set dir=up. Triangle wave, no wrap.
  - LED <= {N_LED{pwm_cnt < level}}, registered, one clock latency; level 0 gives LEDs fully off.
- After reset with MODE != 0: the first active edge re-initialises (mode_q 0 -> MODE). Stepping starts from the initial state.
- SPEED may change any cycle; the new value takes effect on the next accumulation. No glitch handling is needed.
- All outputs come from flops; no combinational path from inputs to LED or STEP.

Test Plan:
Sim parameters: N_LED=4, CNT_W=4, SPEED_W=4, PWM_W=3.
- Reset/count up:
  - Stimulus: RESET_N low 3 cycles, then high; MODE=0, SPEED=1.
  - Required: LED=0 and STEP=0 during reset. STEP pulses every 16 cycles. LED goes 1,2,…,15,0, wrapping on the 16th step.
- Speed/down:
  - Stimulus: MODE=1, SPEED=4.
  - Required: STEP every 4 cycles. LED 0→15→14… SPEED=0 for 40 cycles gives no STEP and LED frozen.
- Scan bounce:
  - Stimulus: MODE 0→2, SPEED=8.
  - Required: re-init edge gives LED=0001 with no STEP. Then every 2 cycles LED is 0010,0100,1000,0100,0010,0001,0010.
- Breathe:
  - Stimulus: MODE=3, SPEED=15.
  - Required: level ramps 0..7..0. At level=3, LED=1111 for exactly 3 of every 8 clocks. At level=0, LED stays 0000.
- HOLD and simultaneous events:
  - HOLD=1 for 50 cycles in COUNT_UP: no STEP and LED constant; release resumes from the held acc.
  - MODE change on the carry edge: no STEP, pattern re-initialised.
- Reset mid-operation:
  - Stimulus: assert RESET_N low during SCAN at LED=0100.
  - Required: next edge gives LED=0, STEP=0, mode_q=0. On release with MODE=2, LED=0001 after one edge.
